uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among N byte requesters. It latches the winning requester's byte and issues the transmitter's start command. It then tracks the transmitter's ready signal through the whole frame and returns a per-requester completion pulse. It sits between client blocks (command responder, status reporter, debug dump) and the single UART TX serializer.

Parameters:
N, 4, number of requesters (2..8)
PTR_W, 2, width of round-robin pointer, must equal ceil(log2(N))
TIMEOUT_CYCLES, 64, cycles allowed in ISSUE for tx_ready to fall (used only with optional feature)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req  input  N  per-requester byte request, level; hold until ack
req_data  input  8*N  byte for requester i on bits [8i+7:8i]
grant  output  N  one-hot, high while requester owns transmitter
ack  output  N  one-cycle pulse to owner when its frame completes
busy  output  1  high whenever state != IDLE
tx_send  output  1  start command to transmitter
tx_data  output  8  byte to transmitter, stable while tx_send or grant high
tx_ready  input  1  transmitter idle flag, 1=idle, 0=frame in progress
err  output  1  one-cycle timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, ack=0, busy=0, tx_send=0, tx_data=8'h00, ptr=0, err=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - ack=0, tx_send=0.
  - If tx_ready==1 and |req: select the first i with req[i]=1, scanning ptr, ptr+1, ... mod N.
  - Next cycle: grant[i]=1, tx_data=req_data[i], tx_send=1, busy=1, state=ISSUE.
  - If tx_ready==0: no grant, regardless of req.
- ISSUE:
  - tx_send held 1 until tx_ready==0 is sampled.
  - On that sample: tx_send=0, state=WAIT_DONE.
- WAIT_DONE:
  - On sampling tx_ready==1: ack[i]=1 for one cycle, grant=0, busy=0, ptr=(i+1) mod N, state=IDLE.
- Latency:
  - req sampled in IDLE -> grant/tx_send asserted 1 cycle later.
  - tx_ready rising in WAIT_DONE -> ack 1 cycle later.
- Back-to-back: at least one IDLE cycle (the ack cycle) between grants. A requester whose req is still high in the ack cycle is eligible again but has lowest priority.
- Owner deasserting req mid-transfer: ignored; frame completes and ack is still issued.
- req_data changes after grant: ignored; tx_data stays latched until the next grant.
- Non-owner req changes: no effect until the next IDLE.
- Simultaneous reqs: exactly one grant; round-robin guarantees each requester is served within N frames.
- Reset mid-frame: all outputs return to reset values immediately; no ack is issued for the aborted frame.
- Non-power-of-2 N: pointer wrap uses mod N, never indexes ≥N.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: a counter runs in ISSUE. If tx_ready has not fallen after TIMEOUT_CYCLES cycles:
  - err=1 for one cycle
  - tx_send=0, grant=0, no ack
  - ptr advances past the owner, state=IDLE
  - Counter clears on leaving ISSUE.
- Undefined: no counter; ISSUE waits indefinitely; err tied 0.

Test Plan:
- Reset with req=4'b1111, tx_ready=1 -> all outputs 0 during reset. First cycle after reset release: grant=4'b0001, tx_data=req_data[7:0]=8'hA5, tx_send=1.
- Single req[2]=1, data 8'h3C. Model drops tx_ready 2 cycles after tx_send and raises it 160 cycles later -> tx_send drops the cycle after tx_ready falls; ack=4'b0100 pulses once 1 cycle after tx_ready rises; busy falls with ack.
- req=4'b1111 held continuously -> grant order 0001, 0010, 0100, 1000, 0001; tx_data 8'h10, 8'h11, 8'h12, 8'h13 matches each owner.
- Owner req[1] deasserted and req_data[15:8] changed 8'h55->8'hFF during WAIT_DONE -> tx_data stays 8'h55; ack[1] still pulses.
- tx_ready held 0 in IDLE with req=4'b0001 -> no grant and busy=0 until tx_ready=1.
- With UART_ARB_TIMEOUT_EN, tx_ready stuck at 1 after grant -> err pulses once after 64 cycles in ISSUE; grant=0, ack=0; next grant goes to the next requester. Without the macro, state stays in ISSUE and err=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX serializer among N byte requesters.
// Optional macro UART_ARB_TIMEOUT_EN aborts a grant whose transmitter never starts.
module uart_tx_arbiter #(
    parameter int N              = 4,
    parameter int PTR_W          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic           busy,
    output logic           tx_send,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    output logic           err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d, ack_q, ack_d;
    logic             tx_send_q, tx_send_d, err_q, err_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, owner_q, owner_d, sel, idx, ptr_next;
    logic             found, timeout;
    // Scan from the highest offset down so the entry closest to ptr wins.
    always_comb begin
        sel = '0;
        found = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr_q) + k) % N);
            if (req[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    assign ptr_next = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d = (state_q == ISSUE && state_d == ISSUE) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d = '0;
        tx_send_d = tx_send_q;
        tx_data_d = tx_data_q;
        ptr_d = ptr_q;
        owner_d = owner_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tx_send_d = 1'b0;
                if (tx_ready && found) begin
                    state_d = ISSUE;
                    grant_d = N'(1) << sel;
                    owner_d = sel;
                    tx_send_d = 1'b1;
                    tx_data_d = req_data[{sel, 3'b000} +: 8];
                end
            end
            ISSUE: begin
                if (!tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (timeout) begin
                    err_d = 1'b1;
                    tx_send_d = 1'b0;
                    grant_d = '0;
                    ptr_d = ptr_next;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    ack_d = grant_q;
                    grant_d = '0;
                    ptr_d = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q <= '0;
            tx_send_q <= 1'b0;
            tx_data_q <= 8'h00;
            ptr_q <= '0;
            owner_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q <= ack_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            err_q <= err_d;
        end
    end
    assign grant = grant_q;
    assign ack = ack_q;
    assign busy = (state_q != IDLE);
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;
    assign err = err_q;
endmodule
